fc_neuron_stream: RTL and testbench

Time-multiplexed, parametrised successor to the fully-combinational FC neuron. Computes one output neuron `z = act(bias + Σ x[i]·w[i])` over `IN` inputs. Each handshake beat consumes `LANES` activation/weight pairs, so the per-neuron multiplier count drops from `IN` to `LANES`. Weights arrive at run time instead of being hard-wired as constant multipliers. Sits between the activation buffer and the next layer; the result leaves on a valid/ready stream.

---
 rtl/fc_neuron_stream.sv | 144 ++++++++++++++
 tb/tb_fc_neuron_stream.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_neuron_stream.sv
// fc_lane_mul: one signed WIDTH x WIDTH multiplier lane.
//   a, b : signed operands
//   p    : full-precision signed product (2*WIDTH bits)
module fc_lane_mul #(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] p
);
  localparam int PW = 2 * WIDTH;
  assign p = PW'(a) * PW'(b);
endmodule

// fc_neuron_stream: time-multiplexed fully-connected neuron.
//   z = act(bias + sum_i x[i]*w[i]) over IN inputs, LANES pairs per beat.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  input beat handshake (x, w, and bias on beat 0)
//   x, w                 LANES packed signed WIDTH-bit activations / weights
//   bias                 signed 2*WIDTH bias, sampled on beat 0 only
//   out_valid/out_ready  result handshake
//   z                    signed ACC_W result (non-negative when RELU=1)
module fc_neuron_stream #(
  parameter  int WIDTH = 8,
  parameter  int IN    = 128,
  parameter  int LANES = 4,
  parameter  int RELU  = 1,
  localparam int ACC_W = 2*WIDTH + $clog2(IN) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   x,
  input  logic [LANES*WIDTH-1:0]   w,
  input  logic [2*WIDTH-1:0]       bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  z
);
  localparam int BEATS = IN / LANES;
  localparam int LVL   = $clog2(LANES);
  localparam int NP    = 1 << LVL;           // lanes padded to a power of two
  localparam int SUM_W = 2*WIDTH + LVL;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  generate
    if (LANES < 1 || LANES > IN || (IN % LANES) != 0) begin : g_bad_cfg
      $error("fc_neuron_stream: IN must be a multiple of LANES, 1 <= LANES <= IN");
    end
  endgenerate

  // Whole pipeline shares one enable: it stalls only while a finished
  // result is waiting for downstream.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic accept;
  assign accept = in_valid && in_ready;

  // ---------------- lane multipliers + balanced adder tree ----------------
  logic [LANES-1:0][2*WIDTH-1:0] prod;
  // Heap-ordered tree: node i sums nodes 2i+1 and 2i+2, leaves at NP-1..2NP-2.
  // Every node is carried at the final SUM_W width with sign extension,
  // which holds the same value as growing one bit per level.
  logic signed [SUM_W-1:0] node [2*NP-1];

  for (genvar k = 0; k < NP; k++) begin : g_lane
    if (k < LANES) begin : g_mul
      fc_lane_mul #(.WIDTH(WIDTH)) u_mul (
        .a (signed'(x[k*WIDTH +: WIDTH])),
        .b (signed'(w[k*WIDTH +: WIDTH])),
        .p (prod[k])
      );
      assign node[NP-1+k] = SUM_W'(signed'(prod[k]));
    end else begin : g_pad
      assign node[NP-1+k] = '0;
    end
  end

  for (genvar i = 0; i < NP-1; i++) begin : g_tree
    assign node[i] = node[2*i+1] + node[2*i+2];
  end

  // ---------------- beat counter ----------------
  logic [BW-1:0] bcnt;
  logic          first_b, last_b;
  assign first_b = (bcnt == '0);
  assign last_b  = (bcnt == BW'(BEATS-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      bcnt <= '0;
    else if (accept) bcnt <= last_b ? '0 : bcnt + BW'(1);
  end

  // ---------------- stage 1: registered lane sum ----------------
  logic                     s1_v, s1_first, s1_last;
  logic signed [SUM_W-1:0]  s1_sum;
  logic signed [2*WIDTH-1:0] s1_bias;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_sum   <= '0;
      s1_bias  <= '0;
    end else if (en) begin
      s1_v <= in_valid;
      if (accept) begin
        s1_sum   <= node[0];
        s1_first <= first_b;
        s1_last  <= last_b;
        if (first_b) s1_bias <= signed'(bias);
      end
    end
  end

  // ---------------- stage 2: accumulate + activation ----------------
  logic signed [ACC_W-1:0] acc, acc_next, z_act;

  // The first beat restarts from the bias, so a stale acc never leaks in.
  assign acc_next = (s1_first ? ACC_W'(s1_bias) : acc) + ACC_W'(s1_sum);
  assign z_act    = (RELU != 0 && acc_next[ACC_W-1]) ? '0 : acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      z         <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      if (s1_v) begin
        acc <= acc_next;
        if (s1_last) z <= z_act;
      end
      // A new result replacing a consumed one keeps out_valid high.
      if (s1_v && s1_last) out_valid <= 1'b1;
      else if (out_ready)  out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fc_neuron_stream.sv
// Testbench for fc_neuron_stream: five instances with different IN/LANES/RELU
// share one clock. Stimulus pushes expected results into per-instance queues;
// a monitor pops and compares on every output handshake.
module tb_fc_neuron_stream;
  localparam int NI = 5;
  localparam int CIN [NI] = '{8, 8, 128, 16, 128};
  localparam int CL  [NI] = '{4, 4, 4,   1,  128};
  localparam int CR  [NI] = '{1, 0, 1,   0,  1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1023:0] xv [NI];
  logic [1023:0] wv [NI];
  logic [15:0]   bv [NI];
  logic          iv [NI];
  logic          irdy [NI];
  logic          ov [NI];
  logic          ordy [NI];
  longint        zv [NI];

  longint expq [NI][$];
  int     hs_t [NI][$];
  int     rdy_pct [NI];
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;

  for (genvar g = 0; g < NI; g++) begin : gd
    localparam int AW = 2*8 + $clog2(CIN[g]) + 1;
    localparam int LW = CL[g] * 8;
    logic signed [AW-1:0] zl;
    fc_neuron_stream #(.WIDTH(8), .IN(CIN[g]), .LANES(CL[g]), .RELU(CR[g])) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (irdy[g]),
      .x         (xv[g][LW-1:0]),
      .w         (wv[g][LW-1:0]),
      .bias      (bv[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .z         (zl)
    );
    assign zv[g] = longint'(zl);
  end

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: random with a per-instance percentage.
  always begin
    @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) ordy[g] = ($urandom_range(99) < rdy_pct[g]);
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (rst_n && ov[g] && ordy[g]) begin
        check("result expected", longint'(expq[g].size() > 0), 1);
        if (expq[g].size() > 0) check("z", zv[g], expq[g].pop_front());
        hs_t[g].push_back(cyc);
      end
    end
  end

  // mode 0 random, 1 x=w=1 bias=0, 2 x=-3 w=5 bias=10, 3 x=w=-128 bias=32767
  task automatic send_vec(input int g, input int gap, input int mode);
    int n, l, bias, t;
    int xa [128];
    int wa [128];
    longint s;
    bit ok;
    n = CIN[g];
    l = CL[g];
    case (mode)
      1:       bias = 0;
      2:       bias = 10;
      3:       bias = 32767;
      default: bias = int'($urandom_range(65535)) - 32768;
    endcase
    for (int i = 0; i < n; i++) begin
      case (mode)
        1:       begin xa[i] = 1;    wa[i] = 1;    end
        2:       begin xa[i] = -3;   wa[i] = 5;    end
        3:       begin xa[i] = -128; wa[i] = -128; end
        default: begin
          xa[i] = int'($urandom_range(255)) - 128;
          wa[i] = int'($urandom_range(255)) - 128;
        end
      endcase
    end
    // Reference: plain dot product plus bias, then optional ReLU.
    s = bias;
    for (int i = 0; i < n; i++) s += longint'(xa[i]) * longint'(wa[i]);
    if (CR[g] != 0 && s < 0) s = 0;
    expq[g].push_back(s);

    for (int b = 0; b < n / l; b++) begin
      while ($urandom_range(99) < gap) begin
        iv[g] = 1'b0;
        xv[g] = {32{$urandom}};
        bv[g] = 16'($urandom);
        @(posedge clk);
        #1;
      end
      for (int k = 0; k < l; k++) begin
        xv[g][k*8 +: 8] = 8'(xa[b*l + k]);
        wv[g][k*8 +: 8] = 8'(wa[b*l + k]);
      end
      bv[g] = (b == 0) ? 16'(bias) : 16'($urandom);
      iv[g] = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        ok = irdy[g];
        @(posedge clk);
        #1;
        t++;
      end while (!ok && t < 2000);
      check("beat accepted", longint'(ok), 1);
    end
    iv[g] = 1'b0;
  endtask

  task automatic drain(input int g);
    int t;
    t = 0;
    while (expq[g].size() != 0 && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain", longint'(expq[g].size()), 0);
  endtask

  localparam int NV [NI] = '{1000, 200, 60, 1000, 1000};

  initial begin
    longint zh;
    int t;
    for (int g = 0; g < NI; g++) begin
      iv[g] = 1'b0; xv[g] = '0; wv[g] = '0; bv[g] = '0; rdy_pct[g] = 100;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check("rst out_valid", longint'(ov[g]), 0);
      check("rst z", zv[g], 0);
      check("rst in_ready", longint'(irdy[g]), 1);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // One beat of a vector, then reset mid-vector: it must be discarded.
    for (int k = 0; k < 4; k++) begin
      xv[0][k*8 +: 8] = 8'd2;
      wv[0][k*8 +: 8] = 8'd3;
    end
    bv[0] = 16'd100;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst out_valid", longint'(ov[0]), 0);
    check("midrst z", zv[0], 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_vec(0, 0, 1);
    drain(0);

    // Signed sum with and without ReLU
    send_vec(0, 0, 2);
    drain(0);
    send_vec(1, 0, 2);
    drain(1);

    // Worst-case magnitude
    send_vec(2, 0, 3);
    drain(2);

    // Back-to-back: results exactly BEATS cycles apart
    hs_t[0].delete();
    for (int v = 0; v < 4; v++) send_vec(0, 0, 0);
    drain(0);
    check("b2b count", longint'(hs_t[0].size()), 4);
    if (hs_t[0].size() == 4)
      for (int i = 1; i < 4; i++)
        check("b2b spacing", longint'(hs_t[0][i] - hs_t[0][i-1]), CIN[0] / CL[0]);

    // Back-pressure: held result blocks input and stays stable
    rdy_pct[0] = 0;
    repeat (2) begin @(posedge clk); #1; end
    send_vec(0, 0, 0);
    t = 0;
    while (!ov[0] && t < 20) begin @(posedge clk); #1; t++; end
    check("bp out_valid", longint'(ov[0]), 1);
    zh = zv[0];
    iv[0] = 1'b1;
    xv[0] = {32{$urandom}};
    wv[0] = {32{$urandom}};
    repeat (3) begin
      @(negedge clk);
      check("bp in_ready", longint'(irdy[0]), 0);
      check("bp z stable", zv[0], zh);
      @(posedge clk);
      #1;
    end
    iv[0] = 1'b0;
    rdy_pct[0] = 100;
    send_vec(0, 0, 0);
    drain(0);

    // Random gaps and back-pressure
    for (int g = 0; g < NI; g++) begin
      rdy_pct[g] = 60;
      for (int v = 0; v < NV[g]; v++) send_vec(g, 30, 0);
      rdy_pct[g] = 100;
      drain(g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
